mux_gate_sequencer: RTL and testbench

MUX_GATE_SEQUENCER -- requirements
Module: mux_gate_sequencer

---
 rtl/mux_gate_sequencer.sv | 118 +++++++++++
 tb/tb_mux_gate_sequencer.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mux_gate_sequencer.sv
// Bit-serial logic unit: AND / OR / NOT(a) computed LSB first through one 2:1 mux
// gate cell whose select is the current bit of operand A.
module mux_gate_sequencer #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             err
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [1:0] OP_AND = 2'b00;
    localparam logic [1:0] OP_OR  = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, res_sr;
    logic [1:0]       op_q;
    logic [CW-1:0]    cnt;
    logic             accept, last_bit;
    logic             gate_in0, gate_in1, gate_out;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values, independent of block ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    assign last_bit = (cnt == CW'(WIDTH - 1));

    // NOTE: every output of this block gets a default first, so no path leaves
    // a signal unassigned and no latch is inferred.
    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        case (state)
            IDLE: if (start) begin
                accept   = 1'b1;
                state_nx = (op == OP_RSV) ? DONE : RUN;
            end
            RUN:     if (last_bit) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Data inputs of the single mux cell, chosen by the captured opcode.
    always_comb begin
        gate_in0 = 1'b0;
        gate_in1 = 1'b0;
        case (op_q)
            OP_AND: begin gate_in0 = 1'b0;    gate_in1 = b_sr[0]; end
            OP_OR:  begin gate_in0 = b_sr[0]; gate_in1 = 1'b1;    end
            OP_NOT: begin gate_in0 = 1'b1;    gate_in1 = 1'b0;    end
            default: begin gate_in0 = 1'b0;   gate_in1 = 1'b0;    end
        endcase
    end

    assign gate_out = a_sr[0] ? gate_in1 : gate_in0;

    // NOTE: shift registers and counter are reset too, so an aborted run
    // leaves no stale operand or partial result behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            op_q   <= '0;
            cnt    <= '0;
        end else if (accept) begin
            a_sr   <= a;
            b_sr   <= b;
            op_q   <= op;
            res_sr <= '0;
            cnt    <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= {gate_out, res_sr[WIDTH-1:1]};
            cnt    <= cnt + CW'(1);
        end
    end

    // Outputs are loaded only on leaving DONE and hold until the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done   <= 1'b0;
            result <= '0;
            err    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == DONE) begin
                done   <= 1'b1;
                result <= res_sr;
                err    <= (op_q == OP_RSV);
            end
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_mux_gate_sequencer.sv
// Self-checking bench for mux_gate_sequencer: directed cases plus randomized
// operations compared against a word-level reference model.
module tb_mux_gate_sequencer;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [1:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, err;
    logic [W-1:0] result;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] prev_result;
    logic         prev_err;

    mux_gate_sequencer #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .op     (op),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
        .result (result),
        .err    (err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Word-level reference: the serial datapath must reproduce plain bitwise logic.
    task automatic model(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                         output logic [W-1:0] r, output logic e);
        e = 1'b0;
        case (o)
            2'b00:   r = av & bv;
            2'b01:   r = av | bv;
            2'b10:   r = ~av;
            default: begin r = '0; e = 1'b1; end
        endcase
    endtask

    // One operation: accept, scramble inputs, track busy/done cycle by cycle.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] av, input logic [W-1:0] bv,
                          input bit disturb, input bit chain);
        logic [W-1:0] er;
        logic         ee;
        int           lat;
        model(o, av, bv, er, ee);
        lat = (o == 2'b11) ? 1 : W + 1;

        start = 1'b1; op = o; a = av; b = bv;
        tick();
        check("c0_busy", 32'(busy), 32'd1);
        check("c0_done", 32'(done), 32'd0);
        check("c0_result_held", 32'(result), 32'(prev_result));
        start = 1'b0;
        a  = W'($urandom);
        b  = W'($urandom);
        op = 2'($urandom_range(3, 0));

        for (int k = 1; k <= lat; k++) begin
            if (disturb && k >= 2 && k <= W) begin
                start = 1'b1;
                a     = W'($urandom);
                b     = W'($urandom);
                op    = 2'($urandom_range(2, 0));
            end else begin
                start = 1'b0;
            end
            tick();
            check($sformatf("done_k%0d", k), 32'(done), 32'(k == lat));
            check($sformatf("busy_k%0d", k), 32'(busy), 32'(k < lat));
            if (k < lat) begin
                check("result_held", 32'(result), 32'(prev_result));
                check("err_held", 32'(err), 32'(prev_err));
            end else begin
                check($sformatf("result_op%0d", o), 32'(result), 32'(er));
                check($sformatf("err_op%0d", o), 32'(err), 32'(ee));
            end
        end
        start = 1'b0;
        prev_result = er;
        prev_err    = ee;

        if (!chain) begin
            tick();
            check("done_one_cycle", 32'(done), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
            check("result_hold_idle", 32'(result), 32'(prev_result));
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; op = '0; a = '0; b = '0;
        prev_result = '0; prev_err = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst_n = 1'b1;
        tick();

        // Directed vectors
        run_op(2'b00, 8'hA5, 8'h3C, 1'b0, 1'b0);
        check("and_vec", 32'(prev_result), 32'h24);
        run_op(2'b01, 8'hA5, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("or_hold", 32'(result), 32'hBD);
        end
        run_op(2'b10, 8'hA5, 8'hFF, 1'b0, 1'b0);
        run_op(2'b11, 8'hFF, 8'hFF, 1'b0, 1'b0);
        run_op(2'b00, 8'hA5, 8'h3C, 1'b1, 1'b0);

        // Start in the first IDLE cycle after DONE is accepted.
        run_op(2'b01, 8'h12, 8'h40, 1'b0, 1'b1);
        run_op(2'b10, 8'h0F, 8'h00, 1'b0, 1'b1);
        run_op(2'b11, 8'h33, 8'h44, 1'b0, 1'b0);

        // Randomized operations, including reserved op and busy-time starts.
        for (int n = 0; n < 30; n++) begin
            run_op(2'($urandom_range(3, 0)), W'($urandom), W'($urandom),
                   1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)));
        end

        // Reset mid-run aborts without a done pulse.
        run_op(2'b01, 8'hF0, 8'h0F, 1'b0, 1'b0);
        start = 1'b1; op = 2'b00; a = 8'hA5; b = 8'h3C;
        tick();
        start = 1'b0;
        for (int k = 1; k <= 4; k++) tick();
        check("pre_rst_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy), 32'd0);
        check("async_result", 32'(result), 32'd0);
        check("async_err", 32'(err), 32'd0);
        check("async_done", 32'(done), 32'd0);
        tick();
        rst_n = 1'b1;
        prev_result = '0;
        prev_err    = 1'b0;
        for (int k = 0; k < W + 3; k++) begin
            tick();
            check("no_done_after_abort", 32'(done), 32'd0);
            check("idle_after_abort", 32'(busy), 32'd0);
        end
        run_op(2'b00, 8'hFF, 8'h0F, 1'b0, 1'b0);
        check("post_rst_and", 32'(result), 32'h0F);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
